// File: rtl/stack_mc_pkg.sv
// Shared types for the multicycle stack-machine core: opcodes, FSM states
// and fault codes.
package stack_mc_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_NOT  = 3'b011,
    OP_PUSH = 3'b100,
    OP_POP  = 3'b101,
    OP_JMP  = 3'b110,
    OP_JZ   = 3'b111
  } opcode_e;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_POP_B  = 4'd2,
    ST_POP_A  = 4'd3,
    ST_EXEC   = 4'd4,
    ST_PUSH_R = 4'd5,
    ST_MEM_RD = 4'd6,
    ST_MEM_WR = 4'd7,
    ST_FAULT  = 4'd8
  } state_e;

  localparam logic [1:0] FAULT_NONE      = 2'b00;
  localparam logic [1:0] FAULT_OVERFLOW  = 2'b01;
  localparam logic [1:0] FAULT_UNDERFLOW = 2'b10;

endpackage

// File: rtl/stack_mc_lifo.sv
// Operand LIFO for the stack core: DEPTH x DATA_W, one push or pop per cycle.
// Build option STACK_GUARD_EN: when defined, a push at full or a pop at empty
// is ignored; otherwise the pointer wraps and the occupancy count saturates.
module stack_mc_lifo
  import stack_mc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      push_data,
  output logic [DATA_W-1:0]      tos,
  output logic [DATA_W-1:0]      pop_data,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   empty,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);

`ifdef STACK_GUARD_EN
  localparam bit GuardEn = 1'b1;
`else
  localparam bit GuardEn = 1'b0;
`endif

  logic [DATA_W-1:0] entries_q [DEPTH];
  logic [PW-1:0]     sp_q, sp_d;
  logic [PW:0]       depth_q, depth_d;
  logic              wr_en_s;
  logic [PW-1:0]     sp_top_s;

  // sp points at the next free slot; the top entry sits just below it.
  assign sp_top_s = sp_q - PW'(1);
  assign empty    = (depth_q == {(PW+1){1'b0}});
  assign full     = (depth_q == (PW+1)'(DEPTH));
  // Raw top slot: when empty this is whatever stale entry the pointer lands on.
  assign pop_data = entries_q[sp_top_s];
  assign tos      = empty ? {DATA_W{1'b0}} : pop_data;
  assign depth    = depth_q;

  // Pointer / occupancy update for a single push or pop.
  always_comb begin
    sp_d    = sp_q;
    depth_d = depth_q;
    wr_en_s = 1'b0;
    if (push && !(GuardEn && full)) begin
      wr_en_s = 1'b1;
      sp_d    = sp_q + PW'(1);
      depth_d = full ? depth_q : depth_q + (PW+1)'(1);
    end else if (pop && !(GuardEn && empty)) begin
      sp_d    = sp_q - PW'(1);
      depth_d = empty ? depth_q : depth_q - (PW+1)'(1);
    end else begin
      sp_d    = sp_q;
      depth_d = depth_q;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q    <= {PW{1'b0}};
      depth_q <= {(PW+1){1'b0}};
    end else begin
      sp_q    <= sp_d;
      depth_q <= depth_d;
    end
  end

  // Entry storage; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      entries_q[sp_q] <= push_data;
    end
  end

endmodule

// File: rtl/stack_mc_core.sv
// Multicycle stack-machine core: fetches opc|addr instructions over a
// req/ready memory port and evaluates them on an internal LIFO.
// Build option STACK_GUARD_EN: when defined, stack overflow/underflow sets a
// sticky fault code and parks the FSM in FAULT until reset.
module stack_mc_core
  import stack_mc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 5,
  parameter int OPC_W       = 3,
  parameter int STACK_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  output logic                           mem_rd,
  output logic                           mem_wr,
  input  logic [DATA_W-1:0]              mem_rdata,
  input  logic                           mem_ready,
  output logic [ADDR_W-1:0]              pc,
  output logic [DATA_W-1:0]              tos,
  output logic [$clog2(STACK_DEPTH):0]   depth,
  output logic [1:0]                     fault
);

  if (DATA_W != OPC_W + ADDR_W) begin : g_bad_width
    $error("stack_mc_core: DATA_W must equal OPC_W + ADDR_W");
  end
  if (OPC_W != 3) begin : g_bad_opc
    $error("stack_mc_core: OPC_W must be 3");
  end
  if ((STACK_DEPTH < 2) || ((STACK_DEPTH & (STACK_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("stack_mc_core: STACK_DEPTH must be a power of two >= 2");
  end

`ifdef STACK_GUARD_EN
  localparam bit GuardEn = 1'b1;
`else
  localparam bit GuardEn = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] r_q, r_d;
  logic [1:0]        fault_q, fault_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  opcode_e           opc_s;
  logic [ADDR_W-1:0] ir_addr_s;
  logic [DATA_W-1:0] alu_s;
  logic              push_s, pop_s;
  logic [DATA_W-1:0] push_data_s;
  logic [DATA_W-1:0] lifo_tos_s, lifo_pop_data_s;
  logic              lifo_empty_s, lifo_full_s;
  logic              rd_hs_s, wr_hs_s;

  assign opc_s     = opcode_e'(ir_q[DATA_W-1 -: OPC_W]);
  assign ir_addr_s = ir_q[ADDR_W-1:0];
  // A transfer happens only when our own request meets mem_ready.
  assign rd_hs_s   = mem_rd_q && mem_ready;
  assign wr_hs_s   = mem_wr_q && mem_ready;

  stack_mc_lifo #(
    .DATA_W (DATA_W),
    .DEPTH  (STACK_DEPTH)
  ) u_lifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (push_data_s),
    .tos       (lifo_tos_s),
    .pop_data  (lifo_pop_data_s),
    .depth     (depth),
    .empty     (lifo_empty_s),
    .full      (lifo_full_s)
  );

  // ALU on the popped operands; A is the older entry, NOT ignores B.
  always_comb begin
    alu_s = a_q;
    case (opc_s)
      OP_ADD:  alu_s = a_q + b_q;
      OP_SUB:  alu_s = a_q - b_q;
      OP_AND:  alu_s = a_q & b_q;
      OP_NOT:  alu_s = ~a_q;
      default: alu_s = a_q;
    endcase
  end

  // FSM next state, datapath register updates and stack commands.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    r_d         = r_q;
    fault_d     = fault_q;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    push_data_s = r_q;
    case (state_q)
      ST_FETCH: begin
        if (rd_hs_s) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (opc_s)
          OP_ADD, OP_SUB, OP_AND: state_d = ST_POP_B;
          OP_NOT, OP_POP:         state_d = ST_POP_A;
          OP_PUSH:                state_d = ST_MEM_RD;
          OP_JMP: begin
            pc_d    = ir_addr_s;
            state_d = ST_FETCH;
          end
          OP_JZ: begin
            // Empty stack reads as tos == 0, so the branch is taken.
            if (lifo_tos_s == {DATA_W{1'b0}}) begin
              pc_d = ir_addr_s;
            end else begin
              pc_d = pc_q;
            end
            state_d = ST_FETCH;
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_POP_B: begin
        if (GuardEn && lifo_empty_s) begin
          fault_d = FAULT_UNDERFLOW;
          state_d = ST_FAULT;
        end else begin
          b_d     = lifo_pop_data_s;
          pop_s   = 1'b1;
          state_d = ST_POP_A;
        end
      end
      ST_POP_A: begin
        if (GuardEn && lifo_empty_s) begin
          fault_d = FAULT_UNDERFLOW;
          state_d = ST_FAULT;
        end else begin
          a_d     = lifo_pop_data_s;
          pop_s   = 1'b1;
          state_d = (opc_s == OP_POP) ? ST_MEM_WR : ST_EXEC;
        end
      end
      ST_EXEC: begin
        r_d     = alu_s;
        state_d = ST_PUSH_R;
      end
      ST_PUSH_R: begin
        if (GuardEn && lifo_full_s) begin
          fault_d = FAULT_OVERFLOW;
          state_d = ST_FAULT;
        end else begin
          push_s  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_MEM_RD: begin
        if (rd_hs_s) begin
          if (GuardEn && lifo_full_s) begin
            fault_d = FAULT_OVERFLOW;
            state_d = ST_FAULT;
          end else begin
            push_s      = 1'b1;
            push_data_s = mem_rdata;
            state_d     = ST_FETCH;
          end
        end else begin
          state_d = ST_MEM_RD;
        end
      end
      ST_MEM_WR: begin
        if (wr_hs_s) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_MEM_WR;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FETCH;
    endcase
  end

  // Memory-port outputs are registered from the state being entered, so the
  // request is already up during the first cycle of FETCH/MEM_RD/MEM_WR.
  always_comb begin
    mem_rd_d = (state_d == ST_FETCH) || (state_d == ST_MEM_RD);
    mem_wr_d = (state_d == ST_MEM_WR);
    if (state_d == ST_FETCH) begin
      mem_addr_d = pc_d;
    end else if ((state_d == ST_MEM_RD) || (state_d == ST_MEM_WR)) begin
      mem_addr_d = ir_d[ADDR_W-1:0];
    end else begin
      mem_addr_d = mem_addr_q;
    end
    if (state_d == ST_MEM_WR) begin
      mem_wdata_d = a_d;
    end else begin
      mem_wdata_d = mem_wdata_q;
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      pc_q        <= {ADDR_W{1'b0}};
      ir_q        <= {DATA_W{1'b0}};
      a_q         <= {DATA_W{1'b0}};
      b_q         <= {DATA_W{1'b0}};
      r_q         <= {DATA_W{1'b0}};
      fault_q     <= FAULT_NONE;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      r_q         <= r_d;
      fault_q     <= fault_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pc        = pc_q;
  assign tos       = lifo_tos_s;
  assign fault     = fault_q;

endmodule

// File: tb/tb_stack_mc_core.sv
// Directed bench for stack_mc_core: a table of ALU programs plus hand-written
// sequences for branches, memory stalls, reset mid-write and stack guarding.
module tb_stack_mc_core;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int OPC_W  = 3;
  localparam int SD     = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd, mem_wr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] tos;
  logic [3:0]        depth;
  logic [1:0]        fault;

  logic [7:0] mem [32];
  logic       ready_en;
  logic       hold_wr;
  int         n_cmp = 0;
  int         n_err = 0;

  stack_mc_core #(
    .DATA_W (DATA_W), .ADDR_W (ADDR_W), .OPC_W (OPC_W), .STACK_DEPTH (SD)
  ) dut (
    .clk (clk), .rst (rst), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
    .mem_rd (mem_rd), .mem_wr (mem_wr), .mem_rdata (mem_rdata),
    .mem_ready (mem_ready), .pc (pc), .tos (tos), .depth (depth), .fault (fault)
  );

  always #5 clk = ~clk;

  assign mem_ready = ready_en && !(hold_wr && mem_wr);
  assign mem_rdata = mem[mem_addr];

  typedef struct {
    logic [2:0] opc;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    int         dmid;
    int         dend;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One clock; the memory model commits a write handshake seen before the edge.
  task automatic tick();
    logic       wr;
    logic [4:0] wa;
    logic [7:0] wd;
    wr = (mem_wr === 1'b1) && (mem_ready === 1'b1);
    wa = mem_addr;
    wd = mem_wdata;
    @(posedge clk);
    if (wr) mem[wa] = wd;
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    ready_en = 1'b1;
    hold_wr  = 1'b0;
    rst      = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_fetch(input logic [4:0] a, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (mem_rd === 1'b1 && mem_addr === a) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk({nm, "_reach"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_write_done(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (mem_wr === 1'b1 && mem_ready === 1'b1) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk({nm, "_wr"}, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    vt[0] = '{3'b000, 8'h05, 8'h07, 8'h0C, 1, 0};
    vt[1] = '{3'b001, 8'h03, 8'h05, 8'hFE, 1, 0};
    vt[2] = '{3'b010, 8'hF0, 8'h3C, 8'h30, 1, 0};
    vt[3] = '{3'b011, 8'h11, 8'h0F, 8'hF0, 2, 1};
    vt[4] = '{3'b000, 8'hFF, 8'h02, 8'h01, 1, 0};
    vt[5] = '{3'b001, 8'h0A, 8'h03, 8'h07, 1, 0};

    // Reset state, sampled while rst is still high.
    clear_mem();
    ready_en = 1'b1;
    hold_wr  = 1'b0;
    rst      = 1'b1;
    tick();
    tick();
    chk("rst_pc", {27'd0, pc}, 32'd0);
    chk("rst_depth", {28'd0, depth}, 32'd0);
    chk("rst_tos", {24'd0, tos}, 32'd0);
    chk("rst_fault", {30'd0, fault}, 32'd0);
    chk("rst_rd_wr", {30'd0, mem_rd, mem_wr}, 32'd0);
    chk("rst_addr", {27'd0, mem_addr}, 32'd0);
    chk("rst_wdata", {24'd0, mem_wdata}, 32'd0);

    // Table: PUSH 30, PUSH 31, <op>, POP 29 with ready tied high.
    for (int v = 0; v < 6; v++) begin
      clear_mem();
      mem[0]  = 8'h9E;
      mem[1]  = 8'h9F;
      mem[2]  = {vt[v].opc, 5'd0};
      mem[3]  = 8'hBD;
      mem[4]  = 8'hC4;
      mem[30] = vt[v].a;
      mem[31] = vt[v].b;
      do_reset();
      wait_fetch(5'd3, $sformatf("v%0d_f3", v));
      chk($sformatf("v%0d_tos", v), {24'd0, tos}, {24'd0, vt[v].res});
      chk($sformatf("v%0d_dmid", v), {28'd0, depth}, vt[v].dmid);
      wait_write_done($sformatf("v%0d", v));
      chk($sformatf("v%0d_mem29", v), {24'd0, mem[29]}, {24'd0, vt[v].res});
      chk($sformatf("v%0d_dend", v), {28'd0, depth}, vt[v].dend);
      chk($sformatf("v%0d_pc", v), {27'd0, pc}, 32'd4);
      chk($sformatf("v%0d_fault", v), {30'd0, fault}, 32'd0);
    end

    // JZ taken on an empty stack (tos reads 0).
    clear_mem();
    mem[0]  = 8'hEA;
    mem[10] = 8'hCA;
    do_reset();
    wait_fetch(5'd10, "jz_taken");
    chk("jz_taken_pc", {27'd0, pc}, 32'd10);
    chk("jz_taken_depth", {28'd0, depth}, 32'd0);

    // JZ not taken with tos = 1: falls through to address 2.
    clear_mem();
    mem[0]  = 8'h9E;
    mem[1]  = 8'hEA;
    mem[2]  = 8'hC2;
    mem[10] = 8'hCA;
    mem[30] = 8'h01;
    do_reset();
    for (int i = 0; i < 50; i++) begin
      if (mem_rd === 1'b1 && (mem_addr === 5'd2 || mem_addr === 5'd10)) break;
      tick();
    end
    chk("jz_fall_addr", {27'd0, mem_addr}, 32'd2);
    chk("jz_fall_depth", {28'd0, depth}, 32'd1);
    chk("jz_fall_tos", {24'd0, tos}, 32'd1);

    // FETCH stalled by mem_ready low for 4 cycles.
    clear_mem();
    mem[0] = 8'hC0;
    do_reset();
    ready_en = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stall%0d_rd", i), {31'd0, mem_rd}, 32'd1);
      chk($sformatf("stall%0d_addr", i), {27'd0, mem_addr}, 32'd0);
      chk($sformatf("stall%0d_pc", i), {27'd0, pc}, 32'd0);
      tick();
    end
    ready_en = 1'b1;
    tick();
    chk("stall_done_pc", {27'd0, pc}, 32'd1);
    chk("stall_done_rd", {31'd0, mem_rd}, 32'd0);

    // Reset while MEM_WR is waiting for ready: write must never land.
    clear_mem();
    mem[0]  = 8'h9E;
    mem[1]  = 8'hBD;
    mem[29] = 8'h55;
    mem[30] = 8'hAA;
    do_reset();
    hold_wr = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (mem_wr === 1'b1) break;
      tick();
    end
    chk("rstwr_in_wr", {31'd0, mem_wr}, 32'd1);
    chk("rstwr_wdata", {24'd0, mem_wdata}, 32'hAA);
    rst = 1'b1;
    tick();
    chk("rstwr_wr", {31'd0, mem_wr}, 32'd0);
    chk("rstwr_pc", {27'd0, pc}, 32'd0);
    chk("rstwr_depth", {28'd0, depth}, 32'd0);
    chk("rstwr_mem29", {24'd0, mem[29]}, 32'h55);
    rst     = 1'b0;
    hold_wr = 1'b0;

`ifdef STACK_GUARD_EN
    // ADD on an empty stack traps as underflow and stops fetching.
    clear_mem();
    mem[0] = 8'h00;
    do_reset();
    for (int i = 0; i < 12; i++) tick();
    chk("unf_fault", {30'd0, fault}, 32'd2);
    chk("unf_pc", {27'd0, pc}, 32'd1);
    chk("unf_depth", {28'd0, depth}, 32'd0);
    begin
      int reqs = 0;
      for (int i = 0; i < 6; i++) begin
        if (mem_rd !== 1'b0 || mem_wr !== 1'b0) reqs++;
        tick();
      end
      chk("unf_no_req", reqs, 32'd0);
    end

    // Nine PUSHes: the ninth hits a full stack and traps as overflow.
    clear_mem();
    for (int i = 0; i < 9; i++) mem[i] = 8'h9E;
    mem[30] = 8'h21;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      if (fault !== 2'b00) break;
      tick();
    end
    tick();
    chk("ovf_fault", {30'd0, fault}, 32'd1);
    chk("ovf_depth", {28'd0, depth}, 32'd8);
    chk("ovf_pc", {27'd0, pc}, 32'd9);
    chk("ovf_rd", {31'd0, mem_rd}, 32'd0);
`else
    // Unguarded: ADD on empty wraps the pointer, result still pushed.
    clear_mem();
    mem[0] = 8'h00;
    mem[1] = 8'hC1;
    do_reset();
    wait_fetch(5'd1, "nog_add");
    chk("nog_add_depth", {28'd0, depth}, 32'd1);
    chk("nog_add_fault", {30'd0, fault}, 32'd0);

    // Unguarded: nine PUSHes saturate depth at 8, no fault.
    clear_mem();
    for (int i = 0; i < 9; i++) mem[i] = 8'h9E;
    mem[9]  = 8'hC9;
    mem[30] = 8'h21;
    do_reset();
    wait_fetch(5'd9, "nog_push");
    chk("nog_push_depth", {28'd0, depth}, 32'd8);
    chk("nog_push_fault", {30'd0, fault}, 32'd0);
    chk("nog_push_tos", {24'd0, tos}, 32'h21);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
